i2c_txn_scheduler: RTL and testbench

- Sequences the I2C transaction engine: it drives dev_address_s, reg_address_s and data_s, and consumes done/ack-fail status.
- After reset it waits for codec power-up, then plays a fixed 11-entry WM8731 configuration table as I2C writes, retrying failed writes.
- It then serves a single user request port (register read/write) for runtime control, for example volume.
- The engine, not this block, produces the start, stop and ack bits.

---
 rtl/i2c_txn_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_scheduler.sv
// Sequences the I2C transaction engine: codec power-up wait, WM8731 init table
// with retries, then a single user register read/write port.
module i2c_txn_scheduler #(
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter logic [19:0] PWR_DELAY = 20'd500000,
  parameter logic [7:0]  GAP       = 8'd100,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       eng_done,
  input  logic       eng_ack_failed,
  input  logic [7:0] eng_rdata,
  output logic [8:0] dev_address_s,
  output logic [7:0] reg_address_s,
  output logic [7:0] data_s,
  input  logic       usr_req,
  input  logic       usr_rw,
  input  logic [7:0] usr_reg,
  input  logic [7:0] usr_wdata,
  output logic       usr_ack,
  output logic       usr_done,
  output logic [7:0] usr_rdata,
  output logic       usr_err,
  output logic       init_done,
  output logic       init_fault
);

  // state      | meaning
  // PWR_WAIT   | waiting for codec power-up after reset
  // INIT_ISSUE | start pulse for current table entry
  // INIT_WAIT  | table write in flight
  // GAP_WAIT   | idle spacing after any transaction
  // IDLE       | init complete, waiting for a user request
  // USR_ISSUE  | start pulse for the latched user request
  // USR_WAIT   | user transaction in flight
  // FAULT      | a table entry exhausted its retries; terminal until reset
  localparam logic [2:0] S_PWR_WAIT   = 3'd0;
  localparam logic [2:0] S_INIT_ISSUE = 3'd1;
  localparam logic [2:0] S_INIT_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP_WAIT   = 3'd3;
  localparam logic [2:0] S_IDLE       = 3'd4;
  localparam logic [2:0] S_USR_ISSUE  = 3'd5;
  localparam logic [2:0] S_USR_WAIT   = 3'd6;
  localparam logic [2:0] S_FAULT      = 3'd7;

  localparam logic [3:0] TBL_LEN = 4'd11;

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic        nack_q, nack_d;
  logic        rw_q, rw_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        usr_done_q, usr_done_d;
  logic        usr_err_q, usr_err_d;
  logic [7:0]  usr_rdata_q, usr_rdata_d;
  logic        init_done_q, init_done_d;
  logic        init_fault_q, init_fault_d;

  logic [6:0] tbl_reg;
  logic [8:0] tbl_dat;
  logic       pwr_tc;
  logic       gap_tc;
  logic       nack_eff;
  logic       last_retry;

  // WM8731 register address is 7 bits; data bit 8 rides in the register byte.
  always_comb begin
    tbl_reg = 7'h00;
    tbl_dat = 9'h000;
    case (idx_q)
      4'd0:    begin tbl_reg = 7'h0F; tbl_dat = 9'h000; end
      4'd1:    begin tbl_reg = 7'h00; tbl_dat = 9'h017; end
      4'd2:    begin tbl_reg = 7'h01; tbl_dat = 9'h017; end
      4'd3:    begin tbl_reg = 7'h02; tbl_dat = 9'h079; end
      4'd4:    begin tbl_reg = 7'h03; tbl_dat = 9'h079; end
      4'd5:    begin tbl_reg = 7'h04; tbl_dat = 9'h012; end
      4'd6:    begin tbl_reg = 7'h05; tbl_dat = 9'h000; end
      4'd7:    begin tbl_reg = 7'h06; tbl_dat = 9'h000; end
      4'd8:    begin tbl_reg = 7'h07; tbl_dat = 9'h00A; end
      4'd9:    begin tbl_reg = 7'h08; tbl_dat = 9'h000; end
      4'd10:   begin tbl_reg = 7'h09; tbl_dat = 9'h001; end
      default: begin tbl_reg = 7'h00; tbl_dat = 9'h000; end
    endcase
  end

  assign pwr_tc     = ({1'b0, cnt_q} + 21'd1) >= {1'b0, PWR_DELAY};
  assign gap_tc     = ({1'b0, cnt_q} + 21'd1) >= {13'd0, GAP};
  assign nack_eff   = nack_q | eng_ack_failed;
  assign last_retry = ({1'b0, retry_q} + 3'd1) >= {1'b0, MAX_RETRY};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    nack_d       = nack_q;
    rw_d         = rw_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    usr_done_d   = 1'b0;
    usr_err_d    = 1'b0;
    usr_rdata_d  = usr_rdata_q;
    init_done_d  = init_done_q;
    init_fault_d = init_fault_q;
    case (state_q)
      S_PWR_WAIT: begin
        if (pwr_tc) begin
          state_d = S_INIT_ISSUE;
          cnt_d   = 20'd0;
          idx_d   = 4'd0;
          retry_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_INIT_ISSUE: begin
        nack_d  = 1'b0;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (eng_ack_failed) nack_d = 1'b1;
        if (eng_done) begin
          cnt_d   = 20'd0;
          state_d = S_GAP_WAIT;
          if (!nack_eff) begin
            idx_d   = idx_q + 4'd1;
            retry_d = 2'd0;
          end else if (!last_retry) begin
            retry_d = retry_q + 2'd1;
          end else begin
            init_fault_d = 1'b1;
            state_d      = S_FAULT;
          end
        end
      end
      S_GAP_WAIT: begin
        if (gap_tc) begin
          cnt_d = 20'd0;
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == TBL_LEN) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_INIT_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_IDLE: begin
        if (usr_req) begin
          rw_d    = usr_rw;
          reg_d   = usr_reg;
          wdata_d = usr_wdata;
          state_d = S_USR_ISSUE;
        end
      end
      S_USR_ISSUE: begin
        nack_d  = 1'b0;
        state_d = S_USR_WAIT;
      end
      S_USR_WAIT: begin
        if (eng_ack_failed) nack_d = 1'b1;
        if (eng_done) begin
          usr_done_d = 1'b1;
          usr_err_d  = nack_eff;
          if (rw_q && !nack_eff) usr_rdata_d = eng_rdata;
          cnt_d   = 20'd0;
          state_d = S_GAP_WAIT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_PWR_WAIT;
      cnt_q        <= 20'd0;
      idx_q        <= 4'd0;
      retry_q      <= 2'd0;
      nack_q       <= 1'b0;
      rw_q         <= 1'b0;
      reg_q        <= 8'h00;
      wdata_q      <= 8'h00;
      usr_done_q   <= 1'b0;
      usr_err_q    <= 1'b0;
      usr_rdata_q  <= 8'h00;
      init_done_q  <= 1'b0;
      init_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      nack_q       <= nack_d;
      rw_q         <= rw_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      usr_done_q   <= usr_done_d;
      usr_err_q    <= usr_err_d;
      usr_rdata_q  <= usr_rdata_d;
      init_done_q  <= init_done_d;
      init_fault_q <= init_fault_d;
    end
  end

  // Bytes are decoded from state so an async reset clears them at once.
  always_comb begin
    dev_address_s = 9'h000;
    reg_address_s = 8'h00;
    data_s        = 8'h00;
    case (state_q)
      S_INIT_ISSUE, S_INIT_WAIT: begin
        dev_address_s = {state_q == S_INIT_ISSUE, DEV_ADDR, 1'b0};
        reg_address_s = {tbl_reg, tbl_dat[8]};
        data_s        = tbl_dat[7:0];
      end
      S_USR_ISSUE, S_USR_WAIT: begin
        dev_address_s = {state_q == S_USR_ISSUE, DEV_ADDR, rw_q};
        reg_address_s = reg_q;
        data_s        = rw_q ? 8'h00 : wdata_q;
      end
      default: ;
    endcase
  end

  assign usr_ack    = (state_q == S_IDLE) & usr_req;
  assign usr_done   = usr_done_q;
  assign usr_err    = usr_err_q;
  assign usr_rdata  = usr_rdata_q;
  assign init_done  = init_done_q;
  assign init_fault = init_fault_q;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Bench for i2c_txn_scheduler: behavioural engine model plus issue-log scoreboard.
module tb_i2c_txn_scheduler;

  localparam logic [6:0] DEV = 7'h1A;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       eng_done, eng_ack_failed;
  logic [7:0] eng_rdata;
  logic [8:0] dev_address_s;
  logic [7:0] reg_address_s, data_s;
  logic       usr_req = 1'b0, usr_rw = 1'b0;
  logic [7:0] usr_reg = 8'h00, usr_wdata = 8'h00;
  logic       usr_ack, usr_done, usr_err, init_done, init_fault;
  logic [7:0] usr_rdata;

  typedef struct packed {
    logic [8:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
  } txn_t;

  txn_t exp_q[$];
  txn_t got_q[$];
  txn_t held_q[$];
  int   nack_list[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   start_cnt = 0;
  int   start_base = 0;
  logic [7:0] rdata_val = 8'h00;

  i2c_txn_scheduler #(
    .DEV_ADDR (7'h1A),
    .PWR_DELAY(20'd10),
    .GAP      (8'd2),
    .MAX_RETRY(2'd3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .eng_done      (eng_done),
    .eng_ack_failed(eng_ack_failed),
    .eng_rdata     (eng_rdata),
    .dev_address_s (dev_address_s),
    .reg_address_s (reg_address_s),
    .data_s        (data_s),
    .usr_req       (usr_req),
    .usr_rw        (usr_rw),
    .usr_reg       (usr_reg),
    .usr_wdata     (usr_wdata),
    .usr_ack       (usr_ack),
    .usr_done      (usr_done),
    .usr_rdata     (usr_rdata),
    .usr_err       (usr_err),
    .init_done     (init_done),
    .init_fault    (init_fault)
  );

  always #5 clock = ~clock;

  function automatic txn_t init_txn(input int i);
    logic [6:0] r;
    logic [8:0] d;
    case (i)
      0:       begin r = 7'h0F; d = 9'h000; end
      1:       begin r = 7'h00; d = 9'h017; end
      2:       begin r = 7'h01; d = 9'h017; end
      3:       begin r = 7'h02; d = 9'h079; end
      4:       begin r = 7'h03; d = 9'h079; end
      5:       begin r = 7'h04; d = 9'h012; end
      6:       begin r = 7'h05; d = 9'h000; end
      7:       begin r = 7'h06; d = 9'h000; end
      8:       begin r = 7'h07; d = 9'h00A; end
      9:       begin r = 7'h08; d = 9'h000; end
      default: begin r = 7'h09; d = 9'h001; end
    endcase
    return {1'b1, DEV, 1'b0, r, d[8], d[7:0]};
  endfunction

  // Engine model: done 5 cycles after each start; NACK on even-numbered
  // attempts comes early, on odd-numbered ones in the same cycle as done.
  initial begin : engine
    txn_t s_t, d_t;
    int   n;
    bit   aborted, nk;
    eng_done = 1'b0; eng_ack_failed = 1'b0; eng_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (reset && dev_address_s[8]) begin
        s_t = {dev_address_s, reg_address_s, data_s};
        d_t = '0;
        n = start_cnt - start_base;
        start_cnt++;
        nk = 1'b0;
        foreach (nack_list[i]) if (nack_list[i] == n) nk = 1'b1;
        aborted = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          @(negedge clock);
          if (!reset) begin aborted = 1'b1; break; end
          eng_ack_failed = nk && (k == 2) && (n % 2 == 0);
          if (k == 4) begin
            d_t = {dev_address_s, reg_address_s, data_s};
            eng_done = 1'b1;
            eng_rdata = rdata_val;
            eng_ack_failed = nk && (n % 2 == 1);
          end
        end
        if (!aborted) @(negedge clock);
        eng_done = 1'b0; eng_ack_failed = 1'b0; eng_rdata = 8'hEE;
        if (!aborted) begin
          got_q.push_back(s_t);
          held_q.push_back(d_t);
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    usr_req = 1'b0; usr_rw = 1'b0; usr_reg = 8'h00; usr_wdata = 8'h00;
    repeat (3) @(negedge clock);
    exp_q.delete(); got_q.delete(); held_q.delete();
    start_base = start_cnt;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (!init_done && !init_fault && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic cycles_to_start(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (dev_address_s[8]) break;
    end
  endtask

  task automatic test_reset();
    int cyc;
    #2 reset = 1'b0;
    #2;
    vectors++; if (dev_address_s !== 9'h000) begin miscompares++; $display("FAIL rst_dev: got %h want 000", dev_address_s); end
    vectors++; if (reg_address_s !== 8'h00) begin miscompares++; $display("FAIL rst_reg: got %h want 00", reg_address_s); end
    vectors++; if (data_s !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h want 00", data_s); end
    vectors++; if ({usr_ack, usr_done, usr_err, init_done, init_fault} !== 5'b0) begin
      miscompares++; $display("FAIL rst_flags: got %b want 00000", {usr_ack, usr_done, usr_err, init_done, init_fault});
    end
    vectors++; if (usr_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata: got %h want 00", usr_rdata); end
    nack_list.delete();
    apply_reset();
    cycles_to_start(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL pwr_delay: got %0d cycles want 10", cyc); end
  endtask

  task automatic test_init_table();
    int cyc;
    txn_t e, g, h, eh;
    for (int i = 0; i < 11; i++) exp_q.push_back(init_txn(i));
    wait_init(cyc);
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL init_done: got %b want 1", init_done); end
    vectors++; if (init_fault !== 1'b0) begin miscompares++; $display("FAIL init_fault: got %b want 0", init_fault); end
    repeat (3) @(negedge clock);
    vectors++; if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL table_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0 && held_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); h = held_q.pop_front();
      eh = e; eh.dev[8] = 1'b0;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL table_issue: got %h want %h", g, e); end
      vectors++; if (h !== eh) begin miscompares++; $display("FAIL table_hold: got %h want %h", h, eh); end
    end
    exp_q.delete();
  endtask

  task automatic test_user_read();
    int cyc;
    txn_t e, g;
    rdata_val = 8'h5A;
    usr_rw = 1'b1; usr_reg = 8'h04; usr_wdata = 8'h77; usr_req = 1'b1;
    exp_q.push_back({9'h135, 8'h04, 8'h00});
    #1;
    cyc = 0;
    while (!usr_ack && cyc < 50) begin @(negedge clock); cyc++; end
    vectors++; if (usr_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %b want 1", usr_ack); end
    @(posedge clock); #1 usr_req = 1'b0;
    @(negedge clock);
    vectors++; if (usr_ack !== 1'b0) begin miscompares++; $display("FAIL rd_ack_pulse: got %b want 0", usr_ack); end
    cyc = 0;
    while (!usr_done && cyc < 50) begin @(negedge clock); cyc++; end
    vectors++; if (usr_done !== 1'b1) begin miscompares++; $display("FAIL rd_done: got %b want 1", usr_done); end
    vectors++; if (usr_rdata !== 8'h5A) begin miscompares++; $display("FAIL rd_data: got %h want 5a", usr_rdata); end
    vectors++; if (usr_err !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b want 0", usr_err); end
    @(negedge clock);
    vectors++; if (usr_done !== 1'b0) begin miscompares++; $display("FAIL rd_done_pulse: got %b want 0", usr_done); end
    repeat (5) @(negedge clock);
    vectors++; if (usr_rdata !== 8'h5A) begin miscompares++; $display("FAIL rd_data_hold: got %h want 5a", usr_rdata); end
    vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL rd_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL rd_issue: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete(); held_q.delete();
  endtask

  task automatic test_user_write_nack();
    int cyc;
    txn_t e, g;
    nack_list.delete();
    nack_list.push_back(11);
    rdata_val = 8'hC3;
    apply_reset();
    usr_rw = 1'b0; usr_reg = 8'h04; usr_wdata = 8'h80; usr_req = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(init_txn(i));
    exp_q.push_back({9'h134, 8'h04, 8'h80});
    cyc = 0;
    while (!usr_ack && cyc < 2000) begin @(negedge clock); cyc++; end
    vectors++; if (usr_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack: got %b want 1", usr_ack); end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL wr_ack_early: init_done %b want 1", init_done); end
    @(posedge clock); #1 usr_req = 1'b0;
    cyc = 0;
    while (!usr_done && cyc < 50) begin @(negedge clock); cyc++; end
    vectors++; if (usr_done !== 1'b1) begin miscompares++; $display("FAIL wr_done: got %b want 1", usr_done); end
    vectors++; if (usr_err !== 1'b1) begin miscompares++; $display("FAIL wr_err: got %b want 1", usr_err); end
    vectors++; if (usr_rdata !== 8'h00) begin miscompares++; $display("FAIL wr_rdata: got %h want 00", usr_rdata); end
    repeat (40) @(negedge clock);
    vectors++; if (start_cnt - start_base != 12) begin
      miscompares++; $display("FAIL wr_no_retry: got %0d starts want 12", start_cnt - start_base);
    end
    vectors++; if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL wr_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL wr_issue: got %h want %h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_retry();
    int cyc;
    txn_t e, g, h, eh;
    nack_list.delete();
    nack_list.push_back(3);
    nack_list.push_back(4);
    apply_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(init_txn(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(init_txn(3));
    for (int i = 4; i < 11; i++) exp_q.push_back(init_txn(i));
    wait_init(cyc);
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL rt_done: got %b want 1", init_done); end
    vectors++; if (init_fault !== 1'b0) begin miscompares++; $display("FAIL rt_fault: got %b want 0", init_fault); end
    repeat (3) @(negedge clock);
    vectors++; if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rt_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0 && held_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); h = held_q.pop_front();
      eh = e; eh.dev[8] = 1'b0;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL rt_issue: got %h want %h", g, e); end
      vectors++; if (h !== eh) begin miscompares++; $display("FAIL rt_hold: got %h want %h", h, eh); end
    end
    exp_q.delete();
  endtask

  task automatic test_fault();
    int cyc, acks;
    txn_t e, g;
    nack_list.delete();
    for (int i = 0; i < 3; i++) nack_list.push_back(i);
    apply_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(init_txn(0));
    wait_init(cyc);
    vectors++; if (init_fault !== 1'b1) begin miscompares++; $display("FAIL ft_fault: got %b want 1", init_fault); end
    repeat (40) @(negedge clock);
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL ft_done: got %b want 0", init_done); end
    vectors++; if (start_cnt - start_base != 3) begin
      miscompares++; $display("FAIL ft_starts: got %0d want 3", start_cnt - start_base);
    end
    vectors++; if (dev_address_s !== 9'h000) begin miscompares++; $display("FAIL ft_dev: got %h want 000", dev_address_s); end
    usr_rw = 1'b1; usr_reg = 8'h04; usr_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (usr_ack) acks++;
    end
    usr_req = 1'b0;
    vectors++; if (acks != 0) begin miscompares++; $display("FAIL ft_usr_ack: got %0d acks want 0", acks); end
    vectors++; if (init_fault !== 1'b1) begin miscompares++; $display("FAIL ft_sticky: got %b want 1", init_fault); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL ft_issue: got %h want %h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc;
    txn_t e;
    nack_list.delete();
    apply_reset();
    cyc = 0;
    while (start_cnt - start_base < 7 && cyc < 500) begin @(negedge clock); cyc++; end
    vectors++; if (start_cnt - start_base < 7) begin
      miscompares++; $display("FAIL rm_reach: got %0d starts want 7", start_cnt - start_base);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    vectors++; if ({dev_address_s, reg_address_s, data_s} !== 25'h0) begin
      miscompares++; $display("FAIL rm_async: got %h %h %h want 0", dev_address_s, reg_address_s, data_s);
    end
    vectors++; if ({usr_ack, usr_done, init_done, init_fault} !== 4'b0) begin
      miscompares++; $display("FAIL rm_flags: got %b want 0000", {usr_ack, usr_done, init_done, init_fault});
    end
    apply_reset();
    cycles_to_start(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL rm_pwr_delay: got %0d want 10", cyc); end
    e = init_txn(0);
    vectors++; if ({dev_address_s, reg_address_s, data_s} !== e) begin
      miscompares++; $display("FAIL rm_first: got %h %h %h want %h", dev_address_s, reg_address_s, data_s, e);
    end
    wait_init(cyc);
    repeat (3) @(negedge clock);
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL rm_done: got %b want 1", init_done); end
    vectors++; if (got_q.size() != 11) begin miscompares++; $display("FAIL rm_count: got %0d want 11", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_init_table();
    test_user_read();
    test_user_write_nack();
    test_retry();
    test_fault();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
